// File: rtl/lut_loader.sv
// Byte-stream loader for a 2^N-entry lookup RAM: packs big-endian bytes into
// DATA_WIDTH-bit words and writes them at ascending addresses, flagging nonzero pad bits.
module lut_loader #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  lut_we,
  output logic [N-1:0]          lut_waddr,
  output logic [DATA_WIDTH-1:0] lut_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [N:0]            words_loaded
);

  localparam int BPW  = (DATA_WIDTH + 7) / 8;
  localparam int WW   = 8 * BPW;
  localparam int SH_W = (BPW > 1) ? 8 * (BPW - 1) : 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  // Bits of the leading byte that lie above DATA_WIDTH.
  localparam logic [WW-1:0] PAD_MASK = ~({WW{1'b1}} >> (WW - DATA_WIDTH));

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     addr;
  logic [BC_W-1:0]  byte_cnt;
  logic [SH_W-1:0]  sh;
  logic [SH_W+7:0]  cat;
  logic [WW-1:0]    word;
  logic             xfer, last_byte, last_word;

  // A byte arriving alongside start is dropped, so start masks the transfer.
  assign xfer      = (state == LOAD) && s_valid && !start;
  assign last_byte = (byte_cnt == BC_W'(BPW - 1));
  assign last_word = (addr == '1);
  assign cat       = {sh, s_data};
  assign word      = cat[WW-1:0];

  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (start)                                state_nxt = LOAD;
        else if (xfer && last_byte && last_word)  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      byte_cnt     <= '0;
      sh           <= '0;
      lut_we       <= 1'b0;
      lut_waddr    <= '0;
      lut_wdata    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      lut_we <= 1'b0;
      if (start) begin
        addr         <= '0;
        byte_cnt     <= '0;
        sh           <= '0;
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
      end else if (xfer) begin
        sh <= cat[SH_W-1:0];
        if (last_byte) begin
          byte_cnt     <= '0;
          lut_we       <= 1'b1;
          lut_waddr    <= addr;
          lut_wdata    <= word[DATA_WIDTH-1:0];
          words_loaded <= words_loaded + 1'b1;
          addr         <= addr + 1'b1;
          if (|(word & PAD_MASK)) err <= 1'b1;
          if (last_word)          done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_loader.sv
// Randomized scoreboard bench for lut_loader: a byte-level table model predicts
// each RAM write; a monitor pops predictions whenever the DUT strobes lut_we.
module tb_lut_loader;

  localparam int N     = 2;
  localparam int DW    = 27;
  localparam int BPW   = (DW + 7) / 8;
  localparam int DEPTH = 1 << N;

  logic          clk, rst_n, start, s_valid, s_ready;
  logic [7:0]    s_data;
  logic          lut_we, busy, done, err;
  logic [N-1:0]  lut_waddr;
  logic [DW-1:0] lut_wdata;
  logic [N:0]    words_loaded;

  lut_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     addr;
    longint data;
    int     wl;
    bit     err;
    bit     done;
    longint cyc;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   sb[$];
  exp_t   mon_e;

  // Reference model state: one table load seen as a list of accepted bytes.
  bit     m_load, m_err, m_done;
  int     m_idx;
  byte unsigned m_bytes[$];
  longint last_addr, last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit st, input bit v, input logic [7:0] d);
    exp_t   e;
    longint val;
    check("s_ready", s_ready, m_load);
    start = st; s_valid = v; s_data = d;
    if (st) begin
      m_load = 1; m_err = 0; m_done = 0; m_idx = 0;
      m_bytes.delete();
    end else if (m_load && v) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == BPW) begin
        val = 0;
        foreach (m_bytes[i]) val = (val << 8) | longint'(m_bytes[i]);
        if ((val >> DW) != 0) m_err = 1;
        e.addr = m_idx;
        e.data = val & ((64'd1 << DW) - 1);
        e.wl   = m_idx + 1;
        e.err  = m_err;
        e.done = (m_idx == DEPTH - 1);
        e.cyc  = cyc + 1;
        sb.push_back(e);
        m_idx++;
        m_bytes.delete();
        if (m_idx == DEPTH) begin m_load = 0; m_done = 1; end
      end
    end
    @(posedge clk); #1;
    start = 0; s_valid = 0;
    check("busy", busy, m_load);
    check("done", done, m_done);
    check("err", err, m_err);
    check("words_loaded", words_loaded, m_idx);
  endtask

  task automatic model_reset();
    m_load = 0; m_err = 0; m_done = 0; m_idx = 0;
    m_bytes.delete();
    sb.delete();
    last_addr = 0; last_data = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_lut_we"}, lut_we, 0);
    check({tag, "_lut_waddr"}, lut_waddr, 0);
    check({tag, "_lut_wdata"}, lut_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  task automatic bytes4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(0, 1, w[8*i +: 8]);
  endtask

  // Monitor: every strobe must match the oldest prediction, in its predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lut_we) begin
        if (sb.size() == 0) begin
          check("we_unexpected", lut_we, 0);
        end else begin
          mon_e = sb.pop_front();
          check("we_cycle", cyc, mon_e.cyc);
          check("we_addr", lut_waddr, mon_e.addr);
          check("we_data", lut_wdata, mon_e.data);
          check("we_words_loaded", words_loaded, mon_e.wl);
          check("we_err", err, mon_e.err);
          check("we_done", done, mon_e.done);
          last_addr = mon_e.addr;
          last_data = mon_e.data;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          check("we_missing", lut_we, 1);
          void'(sb.pop_front());
        end
        check("hold_addr", lut_waddr, last_addr);
        check("hold_data", lut_wdata, last_data);
      end
    end
  end

  initial begin
    rst_n = 0; start = 0; s_valid = 0; s_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 check_all_zero("reset");

    // Bytes offered while idle are never accepted.
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom));

    // Directed full load.
    step(1, 0, 0);
    bytes4(32'h0000_0001); bytes4(32'h0000_0002);
    bytes4(32'h07FF_FFFF); bytes4(32'h0012_3456);
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));

    // Pad error persists through done and clears on the next start.
    step(1, 0, 0);
    bytes4(32'hE000_0001);
    for (int i = 1; i < DEPTH; i++) bytes4(32'h0000_0000);
    step(0, 0, 0); step(0, 1, 8'h55);
    step(1, 0, 0);

    // Gapped stream within one word.
    for (int i = 0; i < 10; i++) step(0, (i % 3) == 0, 8'($urandom));
    for (int i = 0; i < 3; i++) step(0, 0, 8'($urandom));

    // Restart mid-word; the byte issued with start is dropped.
    step(1, 0, 0);
    step(0, 1, 8'h11); step(0, 1, 8'h22);
    step(1, 1, 8'h33);
    bytes4(32'hAABB_CCDD);
    step(0, 0, 0);

    // Asynchronous reset after 6 bytes, then a fresh load.
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom_range(0, 7)));
    #2 rst_n = 0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    step(1, 0, 0);
    for (int i = 0; i < DEPTH * BPW; i++) step(0, 1, 8'($urandom));
    step(0, 0, 0);

    // Random traffic: valid gaps, occasional restarts, occasional pad errors.
    for (int i = 0; i < 3000; i++) begin
      bit st;
      bit v;
      logic [7:0] d;
      st = m_load ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      step(st, v, d);
    end

    repeat (3) step(0, 0, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Write-side counterpart to the BitSieve ROM lookup tables: accepts a byte stream over a valid/ready handshake and packs it into DATA_WIDTH-bit words.
- Emits one write per word to a 2^N-entry lookup RAM at ascending addresses 0 .. 2^N-1.
- Lets annealer coefficient tables be reloaded at run time instead of fixed at elaboration; reports busy, done and a sticky format error.

Parameters:
N, 8, address width; table depth is 2^N entries
DATA_WIDTH, 27, table word width; bytes per word BPW = ceil(DATA_WIDTH/8) (derived localparam, 4 at default)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: begin (or restart) a full-table load
s_data  input  8  stream byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts a byte this cycle
lut_we  output  1  one-cycle write strobe to lookup RAM
lut_waddr  output  N  write address
lut_wdata  output  DATA_WIDTH  write data
busy  output  1  high in LOAD
done  output  1  full table written; held until next start
err  output  1  sticky: nonzero pad bits seen in current load
words_loaded  output  N+1  entries written in current load (0 .. 2^N)

Behaviour:
- Reset (async, rst_n=0): state IDLE. s_ready=0, lut_we=0, lut_waddr=0, lut_wdata=0, busy=0, done=0, err=0, words_loaded=0, byte counter=0. Partial word discarded.
- Byte transfer: happens only on a cycle with s_valid=1 and s_ready=1. s_data is don't-care when s_valid=0.
- States: IDLE, LOAD, DONE.
- IDLE/DONE: s_ready=0. On start: go to LOAD next edge; clear address, byte counter, words_loaded, done and err.
- LOAD: s_ready=1 and busy=1 every cycle. Sustains one byte per cycle with no bubbles between words.
- Packing: big-endian. The first byte of a word is most significant.
- Word value is {b0,..,b(BPW-1)}[DATA_WIDTH-1:0].
- Bits of b0 above DATA_WIDTH within the 8*BPW field are pad bits (the top 5 bits at default width).
- Any nonzero pad bit sets err. The word is still written, truncated. err stays set until the next start.
- Write timing: the cycle after the last byte of a word transfers:
  - lut_we=1 for exactly one cycle, with lut_waddr=current address and lut_wdata=packed word;
  - words_loaded increments in that same cycle;
  - the address increments after the write, with no wrap within a load.
- lut_waddr and lut_wdata hold their last values while lut_we=0.
- Completion: a transfer of the final byte of entry 2^N-1 moves the state to DONE at that edge, so s_ready is 0 from the next cycle.
  - The final lut_we occurs in the first DONE cycle.
  - done=1 from that same cycle, with words_loaded=2^N.
- start during LOAD: restart.
  - Address, byte counter and words_loaded go to 0; err is cleared; the partial word is discarded.
  - If a write strobe was pending from the previous edge, it still issues.
  - A byte transferring in the same cycle as start is dropped.
- start and s_valid in IDLE/DONE: no byte is accepted (s_ready=0).
- Gaps in s_valid: the byte counter holds and no write occurs until BPW bytes have transferred.
- Mid-load reset: immediate return to reset values. The RAM keeps previously written entries; that is not the loader's concern.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; after release, state IDLE with s_ready=0.
- Full load, N=2: start, then 16 back-to-back bytes 00 00 00 01, 00 00 00 02, 07 FF FF FF, 00 12 34 56 -> lut_we pulses at addr 0,1,2,3 with data 0000001, 0000002, 7FFFFFF, 0123456 (hex). Each pulse is one cycle after its 4th byte. done=1 on the 4th pulse; words_loaded=4; err=0; s_ready=0 afterwards.
- Pad error: first byte E0, then 00 00 01 -> err=1; lut_wdata=0000001 written at addr 0. err persists through done and clears on the next start.
- Gapped stream: s_valid toggling 1,0,0,1,... for one word -> exactly one lut_we, one cycle after the 4th accepted byte; no write during gaps.
- Restart mid-word: 2 bytes transferred, then start pulse -> next 4 bytes AA.. written at addr 0; words_loaded=1; the earlier partial bytes never appear.
- Idle bytes / reset mid-load: s_valid=1 in IDLE -> s_ready=0, no write. In another run, rst_n pulse after 6 bytes -> busy=0, words_loaded=0; a new start then reloads from addr 0.
